elevator_call_latch: RTL and testbench



---
 rtl/elevator_call_latch_if.sv | 23 ++
 rtl/elevator_call_latch.sv | 86 ++++++++
 tb/tb_elevator_call_latch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/elevator_call_latch_if.sv
// Hall-call latch bus: raw buttons and controller status in, latched calls and press pulses out.
interface elevator_call_latch_if;
    logic btn1_raw;
    logic btn2_raw;
    logic floor_sensor;
    logic door_open;
    logic motor_up;
    logic motor_down;
    logic call1;
    logic call2;
    logic press1;
    logic press2;

    modport master (
        output btn1_raw, btn2_raw, floor_sensor, door_open, motor_up, motor_down,
        input  call1, call2, press1, press2
    );

    modport slave (
        input  btn1_raw, btn2_raw, floor_sensor, door_open, motor_up, motor_down,
        output call1, call2, press1, press2
    );
endinterface

// File: rtl/elevator_call_latch.sv
// Hall-call front end: synchronize, debounce, edge-detect and latch both floor buttons.
// Optional SAME_FLOOR_FILTER_EN drops presses at the floor where the car is parked.
module elevator_call_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_call_latch_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the floor-1 button, bit 1 the floor-2 button throughout.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       press;
    logic [1:0]       call;
    logic [1:0]       rise;
    logic [1:0]       service;
    logic [1:0]       set_req;
    logic [CNT_W-1:0] cnt [2];

    assign raw     = {bus.btn2_raw, bus.btn1_raw};
    assign service = {bus.door_open & bus.floor_sensor, bus.door_open & ~bus.floor_sensor};

    // A rise is the edge on which the debounced level is about to flip 0->1.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = s2[i] & ~deb[i] & (cnt[i] == CNT_LAST);
        end
    end

`ifdef SAME_FLOOR_FILTER_EN
    logic       parked;
    logic [1:0] at_floor;

    assign parked   = ~bus.motor_up & ~bus.motor_down;
    assign at_floor = {bus.floor_sensor, ~bus.floor_sensor};
    assign set_req  = rise & ~({2{parked}} & at_floor);
`else
    logic unused_motion;

    assign unused_motion = bus.motor_up ^ bus.motor_down;
    assign set_req       = rise;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            deb    <= '0;
            press  <= '0;
            call   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= rise;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                // Service beats a coincident press: the car is already there.
                if (service[i]) begin
                    call[i] <= 1'b0;
                end else if (set_req[i]) begin
                    call[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.call1  = call[0];
    assign bus.call2  = call[1];
    assign bus.press1 = press[0];
    assign bus.press2 = press[1];
endmodule

// File: tb/tb_elevator_call_latch.sv
// Directed bench for elevator_call_latch; expected output vectors are queued with the edge they are due after.
module tb_elevator_call_latch;
    logic clk = 1'b0;
    logic rst;

    elevator_call_latch_if bus ();

    elevator_call_latch #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef SAME_FLOOR_FILTER_EN
    localparam logic FILTER = 1'b1;
`else
    localparam logic FILTER = 1'b0;
`endif

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        edges      = 0;
    int        passCount  = 0;
    int        checkCount = 0;

    always @(posedge clk) edges++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic b1, input logic b2, input logic fs,
                                 input logic door, input logic mu, input logic md);
        bus.btn1_raw     = b1;
        bus.btn2_raw     = b2;
        bus.floor_sensor = fs;
        bus.door_open    = door;
        bus.motor_up     = mu;
        bus.motor_down   = md;
    endtask

    // Vector order is {call1, call2, press1, press2}, due after edge (edges + offset).
    task automatic expectAt(input int offset, input string tag, input logic [3:0] exp);
        sb_entry_t e;
        e.due = edges + offset;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        sb_entry_t  e;
        logic [3:0] observed;
        observed = {bus.call1, bus.call2, bus.press1, bus.press2};
        while (sb.size() > 0 && sb[0].due == edges) begin
            e = sb.pop_front();
            checkCount++;
            assert (observed === e.exp) passCount++;
            else $error("[TB] FAIL %s: observed=%b expected=%b (edge %0d)", e.tag, observed, e.exp, edges);
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        logic c;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        expectAt(2, "reset", 4'b0000);
        tick(2);
        rst = 1'b0;

        $display("[TB] clean press on btn2 at floor 1");
        applyStimulus(0, 1, 0, 0, 0, 0);
        expectAt(5, "press2_early", 4'b0000);
        expectAt(6, "press2_latch", 4'b0101);
        expectAt(7, "press2_pulse_end", 4'b0100);
        tick(20);
        expectAt(0, "press2_hold", 4'b0100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(10);
        expectAt(0, "release2_no_event", 4'b0100);

        $display("[TB] service clear of call2");
        applyStimulus(0, 0, 0, 1, 0, 0);
        expectAt(1, "door_wrong_floor", 4'b0100);
        tick(1);
        applyStimulus(0, 0, 1, 1, 0, 0);
        expectAt(1, "service2", 4'b0000);
        tick(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        tick(2);

        $display("[TB] bounce rejection on btn1");
        for (int rep = 0; rep < 4; rep++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(j != 3, 0, 1, 0, 0, 0);
                expectAt(1, "bounce", 4'b0000);
                tick(1);
            end
        end
        applyStimulus(0, 0, 1, 0, 0, 0);
        expectAt(6, "bounce_tail", 4'b0000);
        tick(6);
        applyStimulus(1, 0, 1, 0, 0, 0);
        expectAt(5, "steady1_early", 4'b0000);
        expectAt(6, "steady1_latch", 4'b1010);
        expectAt(7, "steady1_pulse_end", 4'b1000);
        tick(5);
        applyStimulus(0, 0, 1, 0, 0, 0);
        tick(10);
        expectAt(0, "steady1_hold", 4'b1000);
        applyStimulus(0, 0, 0, 1, 0, 0);
        expectAt(1, "service1", 4'b0000);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(2);

        $display("[TB] press and service on the same edge");
        applyStimulus(1, 0, 0, 0, 0, 0);
        expectAt(5, "simul_early", 4'b0000);
        expectAt(6, "simul_clear_wins", 4'b0010);
        expectAt(7, "simul_after", 4'b0000);
        tick(5);
        applyStimulus(1, 0, 0, 1, 0, 0);
        tick(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick(4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(8);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 1, 0, 0, 0);
        expectAt(6, "pre_reset_latch1", 4'b1010);
        expectAt(7, "pre_reset_pulse_end", 4'b1000);
        tick(8);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(8);
        expectAt(0, "pre_reset_call1", 4'b1000);
        applyStimulus(0, 1, 0, 0, 0, 0);
        tick(4);
        rst = 1'b1;
        expectAt(1, "reset_mid", 4'b0000);
        tick(1);
        rst = 1'b0;
        expectAt(5, "post_reset_early", 4'b0000);
        expectAt(6, "post_reset_latch2", 4'b0101);
        expectAt(7, "post_reset_pulse_end", 4'b0100);
        tick(10);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 1, 1, 0, 0);
        expectAt(1, "service2_again", 4'b0000);
        tick(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        tick(2);

        $display("[TB] same-floor press while parked and while moving");
        c = ~FILTER;
        applyStimulus(1, 0, 0, 0, 0, 0);
        expectAt(6, "parked_press1", {c, 3'b010});
        expectAt(7, "parked_after", {c, 3'b000});
        tick(5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 1, 0, 0);
        expectAt(1, "parked_service", 4'b0000);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        expectAt(6, "moving_press1", 4'b1010);
        expectAt(7, "moving_after", 4'b1000);
        tick(8);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 1, 0, 0);
        expectAt(1, "moving_service", 4'b0000);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(3);

        checkCount++;
        assert (sb.size() == 0) passCount++;
        else $error("[TB] FAIL scoreboard_drained: observed=%0d pending expected=0", sb.size());

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
